// File: rtl/mul4_vector_fitness_driver.sv
// Drives lane-rotated exhaustive 2x2-bit operand vectors into a bit-sliced
// multiplier candidate and scores its product vectors against a golden product.
// Ports:
//   clk, rst (sync, active-high), start
//   busy, done, score, perfect, first_fail_round   status/result
//   a1, a0, b1, b0                                  operand vectors to candidate
//   y3, y2, y1, y0                                  product vectors from candidate
module mul4_vector_fitness_driver #(
  parameter int NUM_ROUNDS    = 16,
  parameter int SETTLE_CYCLES = 1,
  parameter int SCORE_W       = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] score,
  output logic               perfect,
  output logic [4:0]         first_fail_round,
  output logic [15:0]        a1,
  output logic [15:0]        a0,
  output logic [15:0]        b1,
  output logic [15:0]        b0,
  input  logic [15:0]        y3,
  input  logic [15:0]        y2,
  input  logic [15:0]        y1,
  input  logic [15:0]        y0
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(64 * NUM_ROUNDS);
  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
  localparam logic [4:0] NO_FAIL = 5'h1F;

  localparam logic [15:0] BA1 = 16'hFF00;
  localparam logic [15:0] BA0 = 16'hF0F0;
  localparam logic [15:0] BB1 = 16'hCCCC;
  localparam logic [15:0] BB0 = 16'hAAAA;
  localparam logic [15:0] BG3 = 16'h8000;
  localparam logic [15:0] BG2 = 16'h4C00;
  localparam logic [15:0] BG1 = 16'h6AC0;
  localparam logic [15:0] BG0 = 16'hA0A0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_ACCUM,
    S_DONE
  } state_e;

  // Upper half of the doubled word is the left rotation.
  function automatic logic [15:0] rotl16(
    input logic [15:0] v,
    input logic [3:0]  r
  );
    logic [31:0] w;
    w = {v, v} << r;
    return w[31:16];
  endfunction

  function automatic logic [6:0] popcnt64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

  state_e             state_q, state_d;
  logic [4:0]         round_q, round_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  logic [15:0]        a1_q, a1_d, a0_q, a0_d;
  logic [15:0]        b1_q, b1_d, b0_q, b0_d;
  logic [63:0]        g_q, g_d;
  logic [6:0]         match_q, match_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               perfect_q, perfect_d;
  logic [4:0]         ffr_q, ffr_d;

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    cnt_d     = cnt_q;
    a1_d      = a1_q;
    a0_d      = a0_q;
    b1_d      = b1_q;
    b0_d      = b0_q;
    g_d       = g_q;
    match_d   = match_q;
    score_d   = score_q;
    perfect_d = perfect_q;
    ffr_d     = ffr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          score_d   = '0;
          perfect_d = 1'b0;
          ffr_d     = NO_FAIL;
          round_d   = '0;
          state_d   = S_APPLY;
        end
      end
      S_APPLY: begin
        a1_d    = rotl16(BA1, round_q[3:0]);
        a0_d    = rotl16(BA0, round_q[3:0]);
        b1_d    = rotl16(BB1, round_q[3:0]);
        b0_d    = rotl16(BB0, round_q[3:0]);
        g_d     = {rotl16(BG3, round_q[3:0]),
                   rotl16(BG2, round_q[3:0]),
                   rotl16(BG1, round_q[3:0]),
                   rotl16(BG0, round_q[3:0])};
        cnt_d   = SW'(SETTLE_CYCLES - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        match_d = popcnt64(~({y3, y2, y1, y0} ^ g_q));
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        score_d = score_q + SCORE_W'(match_q);
        if (match_q != 7'd64 && ffr_q == NO_FAIL) begin
          ffr_d = round_q;
        end
        if (round_q == LAST_ROUND) begin
          // Resolve perfect here so it is already valid during done.
          perfect_d = (score_d == MAX_SCORE);
          state_d   = S_DONE;
        end else begin
          round_d = round_q + 1'b1;
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      round_q   <= '0;
      cnt_q     <= '0;
      a1_q      <= '0;
      a0_q      <= '0;
      b1_q      <= '0;
      b0_q      <= '0;
      g_q       <= '0;
      match_q   <= '0;
      score_q   <= '0;
      perfect_q <= 1'b0;
      ffr_q     <= NO_FAIL;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      cnt_q     <= cnt_d;
      a1_q      <= a1_d;
      a0_q      <= a0_d;
      b1_q      <= b1_d;
      b0_q      <= b0_d;
      g_q       <= g_d;
      match_q   <= match_d;
      score_q   <= score_d;
      perfect_q <= perfect_d;
      ffr_q     <= ffr_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign score            = score_q;
  assign perfect          = perfect_q;
  assign first_fail_round = ffr_q;
  assign a1               = a1_q;
  assign a0               = a0_q;
  assign b1               = b1_q;
  assign b0               = b0_q;

endmodule

// File: tb/tb_mul4_vector_fitness_driver.sv
// Bench for mul4_vector_fitness_driver: two instances (settle 1 and 3) fed by
// behavioural candidates; expected results queued at start, checked on done.
module tb_mul4_vector_fitness_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0;
  logic        start3 = 1'b0;
  int          mode1 = 0;

  logic        busy1, done1, perfect1;
  logic [10:0] score1;
  logic [4:0]  ffr1;
  logic [15:0] a1_1, a0_1, b1_1, b0_1;
  logic [63:0] yv1;

  logic        busy3, done3, perfect3;
  logic [10:0] score3;
  logic [4:0]  ffr3;
  logic [15:0] a1_3, a0_3, b1_3, b0_3;
  logic [63:0] yv3;

  logic [63:0] d1a, d1b, d1c;
  logic [63:0] d3a, d3b, d3c;

  int nchecks = 0;
  int nfails  = 0;
  int cyc     = 0;
  int dcnt1   = 0;
  int dcnt3   = 0;

  typedef struct {
    int         score;
    bit         lt;
    logic       perf;
    logic [4:0] ffr;
    int         lat;
    int         k;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mul4_vector_fitness_driver #(
    .NUM_ROUNDS(16), .SETTLE_CYCLES(1), .SCORE_W(11)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .busy(busy1), .done(done1), .score(score1),
    .perfect(perfect1), .first_fail_round(ffr1),
    .a1(a1_1), .a0(a0_1), .b1(b1_1), .b0(b0_1),
    .y3(yv1[63:48]), .y2(yv1[47:32]),
    .y1(yv1[31:16]), .y0(yv1[15:0])
  );

  mul4_vector_fitness_driver #(
    .NUM_ROUNDS(16), .SETTLE_CYCLES(3), .SCORE_W(11)
  ) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .busy(busy3), .done(done3), .score(score3),
    .perfect(perfect3), .first_fail_round(ffr3),
    .a1(a1_3), .a0(a0_3), .b1(b1_3), .b0(b0_3),
    .y3(yv3[63:48]), .y2(yv3[47:32]),
    .y1(yv3[31:16]), .y0(yv3[15:0])
  );

  // Lane-wise arithmetic product, the reference candidate.
  function automatic logic [63:0] ideal(
    input logic [15:0] a1, a0, b1, b0
  );
    logic [15:0] y3, y2, y1, y0;
    logic [3:0]  p;
    for (int i = 0; i < 16; i++) begin
      p = {2'b00, a1[i], a0[i]} * {2'b00, b1[i], b0[i]};
      y3[i] = p[3];
      y2[i] = p[2];
      y1[i] = p[1];
      y0[i] = p[0];
    end
    return {y3, y2, y1, y0};
  endfunction

  always @(posedge clk) begin
    d1a <= ideal(a1_1, a0_1, b1_1, b0_1);
    d1b <= d1a;
    d1c <= d1b;
    d3a <= ideal(a1_3, a0_3, b1_3, b0_3);
    d3b <= d3a;
    d3c <= d3b;
  end

  // 16'hE01F is a1 of round 5 (16'hFF00 rotated left by 5).
  always_comb begin
    yv1 = ideal(a1_1, a0_1, b1_1, b0_1);
    case (mode1)
      1: yv1 = '0;
      2: yv1 = ~ideal(a1_1, a0_1, b1_1, b0_1);
      3: if (a1_1 == 16'hE01F) yv1[63:48] = '0;
      4: yv1 = d1c;
      default: ;
    endcase
  end

  assign yv3 = d3c;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nchecks++;
    if (act !== exp) begin
      nfails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp(
    input string       tag,
    input exp_t        e,
    input logic [10:0] sc,
    input logic        pf,
    input logic [4:0]  ff
  );
    if (e.lt) chk({tag, "_score_lt"}, 32'(sc < 11'd1024), 1);
    else      chk({tag, "_score"}, 32'(sc), 32'(e.score));
    chk({tag, "_perfect"}, 32'(pf), 32'(e.perf));
    chk({tag, "_ffr"}, 32'(ff), 32'(e.ffr));
    chk({tag, "_latency"}, 32'(cyc - e.k + 1), 32'(e.lat));
  endtask

  always @(negedge clk) begin
    if (done1) begin
      dcnt1++;
      if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
      else cmp("dut1", q1.pop_front(), score1, perfect1, ffr1);
    end
    if (done3) begin
      dcnt3++;
      if (q3.size() == 0) chk("dut3_unexpected_done", 1, 0);
      else cmp("dut3", q3.pop_front(), score3, perfect3, ffr3);
    end
  end

  task automatic go1(
    input bit         push,
    input int         sc,
    input bit         lt,
    input logic       pf,
    input logic [4:0] ff
  );
    exp_t e;
    @(negedge clk);
    chk("idle_before_start", 32'(busy1), 0);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("busy_rise", 32'(busy1), 1);
    e.score = sc; e.lt = lt; e.perf = pf;
    e.ffr = ff; e.lat = 65; e.k = cyc;
    if (push) q1.push_back(e);
  endtask

  task automatic wait_done1(input int maxc);
    int base = dcnt1;
    int n = 0;
    while (dcnt1 == base && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("dut1_done_seen", 32'(dcnt1 - base), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    exp_t e;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_score", 32'(score1), 0);
    chk("rst_perfect", 32'(perfect1), 0);
    chk("rst_ffr", 32'(ffr1), 32'h1F);
    chk("rst_ops", {a1_1 | a0_1, b1_1 | b0_1}, 0);
    chk("rst_dut3_ffr", 32'(ffr3), 32'h1F);

    // Ideal candidate
    mode1 = 0;
    go1(1, 1024, 0, 1'b1, 5'h1F);
    wait_done1(200);
    chk("ops_held_idle", 32'(a1_1), 32'h7F80);

    // y tied to zero
    mode1 = 1;
    go1(1, 800, 0, 1'b0, 5'd0);
    wait_done1(200);

    // Inverted candidate
    mode1 = 2;
    go1(1, 0, 0, 1'b0, 5'd0);
    wait_done1(200);

    // One bad bit in round 5
    mode1 = 3;
    go1(1, 1023, 0, 1'b0, 5'd5);
    wait_done1(200);

    // 3-register candidate with too short a settle window
    mode1 = 4;
    go1(1, 0, 1, 1'b0, 5'd0);
    wait_done1(200);

    // Same candidate with SETTLE_CYCLES=3
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    e.score = 1024; e.lt = 0; e.perf = 1'b1;
    e.ffr = 5'h1F; e.lat = 97; e.k = cyc;
    q3.push_back(e);
    base = dcnt3;
    for (int n = 0; n < 200 && dcnt3 == base; n++) @(negedge clk);
    chk("dut3_done_seen", 32'(dcnt3 - base), 1);

    // Extra starts while busy and during done
    mode1 = 0;
    base = dcnt1;
    go1(1, 1024, 0, 1'b1, 5'h1F);
    for (int n = 1; n <= 66; n++) begin
      @(negedge clk);
      start1 = (n == 10 || n == 64 || n == 65);
    end
    start1 = 1'b0;
    repeat (80) @(negedge clk);
    chk("single_done", 32'(dcnt1 - base), 1);
    chk("idle_after_run", 32'(busy1), 0);

    // start coincident with rst
    @(negedge clk);
    rst = 1'b1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_start_busy", 32'(busy1), 0);
    @(negedge clk);
    rst = 1'b0;
    start1 = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_start_idle", 32'(busy1), 0);

    // Abort mid-run
    base = dcnt1;
    go1(0, 0, 0, 1'b0, 5'd0);
    repeat (30) @(negedge clk);
    chk("pre_abort_score", 32'(score1 != 0), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_done", 32'(done1), 0);
    chk("abort_score", 32'(score1), 0);
    chk("abort_ops", {a1_1 | a0_1, b1_1 | b0_1}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("abort_no_done", 32'(dcnt1 - base), 0);

    go1(1, 1024, 0, 1'b1, 5'h1F);
    wait_done1(200);
    chk("queue_drained", 32'(q1.size() + q3.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfails);
    $finish;
  end

endmodule
